// File: rtl/prog_pkg.sv
// Shared definitions for the instruction-memory programming path: loader state
// encoding and the frame geometry derived from beat width and memory width.
package prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } prog_state_e;

    localparam int DEF_INPUT_WIDTH = 1;
    localparam int DEF_MEM_WIDTH   = 131;

    function automatic int beats_per_byte(input int input_width);
        return 8 / input_width;
    endfunction

    function automatic int mem_bytes(input int mem_width);
        return (mem_width + 7) / 8;
    endfunction

    // Leading bits of the first byte that fall off the top of the memory.
    function automatic int pad_bits(input int mem_width);
        return 8 * mem_bytes(mem_width) - mem_width;
    endfunction

    localparam int BEATS_PER_BYTE = beats_per_byte(DEF_INPUT_WIDTH);
    localparam int BYTES          = mem_bytes(DEF_MEM_WIDTH);
    localparam int PAD            = pad_bits(DEF_MEM_WIDTH);

endpackage

// File: rtl/prog_loader.sv
// Byte-stream front end that serializes a host image MSB-first into the
// instruction memory programming port and verifies a trailing XOR check byte.
module prog_loader
    import prog_pkg::*;
#(
    parameter int INPUT_WIDTH = 1,
    parameter int MEM_WIDTH   = 131
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   prog_enable,
    output logic                   prog_advance,
    output logic [INPUT_WIDTH-1:0] prog_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output prog_state_e            dbg_state
);

    localparam int L_BPB   = beats_per_byte(INPUT_WIDTH);
    localparam int L_BYTES = mem_bytes(MEM_WIDTH);
    localparam int BCNT_W  = $clog2(L_BYTES + 1);
    localparam int BEAT_W  = (L_BPB > 1) ? $clog2(L_BPB) : 1;

    // Host side: a byte is taken when in_valid & in_ready at a rising edge;
    // in_ready is decoded from state only, so it never depends on in_valid.
    prog_state_e       state_q, state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [7:0]        xor_q, xor_d;
    logic [7:0]        buf_q, buf_d;
    logic              error_q, error_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            beat_q     <= '0;
            xor_q      <= '0;
            buf_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            beat_q     <= beat_d;
            xor_q      <= xor_d;
            buf_q      <= buf_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        beat_d     = beat_q;
        xor_d      = xor_q;
        buf_d      = buf_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_WAIT_BYTE;
                    byte_cnt_d = '0;
                    xor_d      = '0;
                    error_d    = 1'b0;
                end
            end
            ST_WAIT_BYTE: begin
                if (in_valid) begin
                    state_d    = ST_SHIFT;
                    buf_d      = in_data;
                    xor_d      = xor_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    beat_d     = '0;
                end
            end
            ST_SHIFT: begin
                buf_d  = buf_q << INPUT_WIDTH;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(L_BPB - 1)) begin
                    beat_d  = '0;
                    state_d = (byte_cnt_q == BCNT_W'(L_BYTES)) ? ST_CHECK : ST_WAIT_BYTE;
                end
            end
            ST_CHECK: begin
                if (in_valid) begin
                    state_d = ST_DONE;
                    error_d = (in_data != xor_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle handshake.
        if (abort) begin
            state_d = ST_IDLE;
            error_d = 1'b0;
        end
    end

    assign in_ready     = (state_q == ST_WAIT_BYTE) || (state_q == ST_CHECK);
    assign prog_advance = (state_q == ST_SHIFT);
    assign prog_enable  = (state_q == ST_WAIT_BYTE) || (state_q == ST_SHIFT) ||
                          (state_q == ST_CHECK);
    assign busy         = prog_enable;
    assign done         = (state_q == ST_DONE);
    assign error        = error_q;
    // Gated so a buffer left part-shifted by abort never shows outside SHIFT.
    assign prog_data    = prog_advance ? buf_q[7 -: INPUT_WIDTH] : '0;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame sessions from a vector table, plus
// hand-written abort, async-reset and 4-bit-beat sequences.
module tb_prog_loader;
    import prog_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, prog_enable, prog_advance, busy, done, error;
    logic [0:0]  prog_data;
    prog_state_e dbg_state;

    logic        s4_start = 1'b0;
    logic        s4_valid = 1'b0;
    logic [7:0]  s4_data = 8'h00;
    logic        r4_ready, r4_enable, r4_adv, r4_busy, r4_done, r4_error;
    logic [3:0]  r4_data;
    prog_state_e r4_state;

    int checks = 0;
    int errors = 0;

    logic [130:0] mem_model = '0;
    int           adv_total = 0;

    prog_loader #(.INPUT_WIDTH(1), .MEM_WIDTH(131)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .prog_enable(prog_enable), .prog_advance(prog_advance),
        .prog_data(prog_data), .busy(busy), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    prog_loader #(.INPUT_WIDTH(4), .MEM_WIDTH(16)) dut4 (
        .clock(clock), .rst_n(rst_n), .start(s4_start), .abort(1'b0),
        .in_valid(s4_valid), .in_data(s4_data), .in_ready(r4_ready),
        .prog_enable(r4_enable), .prog_advance(r4_adv),
        .prog_data(r4_data), .busy(r4_busy), .done(r4_done), .error(r4_error),
        .dbg_state(r4_state)
    );

    always #5 clock = ~clock;

    // Instruction-memory model: a plain shift register fed by the beats.
    always @(negedge clock) begin
        if (prog_advance) begin
            mem_model <= {mem_model[129:0], prog_data};
            adv_total <= adv_total + 1;
        end
    end

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_byte(input logic [7:0] b, input bit hold, output bit ok);
        int t;
        if (!hold) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        ok = in_ready;
        @(negedge clock);
        if (!hold) in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] first;
        logic [7:0] step;
        logic [7:0] chk_mask;
        bit         hold_valid;
        bit         exp_error;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [135:0] stream;
        logic [7:0]   b;
        logic [7:0]   x;
        int           base;
        bit           ok;

        vecs[0] = '{first: 8'h1F, step: 8'h86, chk_mask: 8'h00, hold_valid: 1'b0, exp_error: 1'b0};
        vecs[1] = '{first: 8'h1F, step: 8'h86, chk_mask: 8'h01, hold_valid: 1'b0, exp_error: 1'b1};
        vecs[2] = '{first: 8'hF0, step: 8'h3B, chk_mask: 8'h00, hold_valid: 1'b1, exp_error: 1'b0};
        vecs[3] = '{first: 8'h5A, step: 8'hC7, chk_mask: 8'h80, hold_valid: 1'b1, exp_error: 1'b1};

        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_prog_enable", prog_enable, 0);
        chk("rst_prog_advance", prog_advance, 0);
        chk("rst_prog_data", prog_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 4; v++) begin
            pulse_start();
            chk("start_in_ready", in_ready, 1);
            chk("start_prog_enable", prog_enable, 1);
            chk("start_busy", busy, 1);
            chk("start_done_clr", done, 0);
            chk("start_error_clr", error, 0);
            base = adv_total;
            x = 8'h00;
            stream = '0;
            for (int i = 0; i < 17; i++) begin
                b = vecs[v].first + 8'(i) * vecs[v].step;
                stream = {stream[127:0], b};
                x = x ^ b;
                send_byte(b, vecs[v].hold_valid, ok);
                chk("data_handshake", ok, 1);
            end
            send_byte(x ^ vecs[v].chk_mask, vecs[v].hold_valid, ok);
            chk("check_handshake", ok, 1);
            chk("frame_done", done, 1);
            chk("frame_prog_enable", prog_enable, 0);
            chk("frame_error", error, vecs[v].exp_error);
            chk("frame_advances", adv_total - base, 136);
            chk("frame_memory", mem_model, stream[130:0]);
        end
        in_valid = 1'b0;
        @(negedge clock);

        // Abort during the 3rd beat of byte 5, with a start ignored mid-SHIFT.
        pulse_start();
        base = adv_total;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h11 * 8'(i + 1), 1'b0, ok);
            chk("abort_handshake", ok, 1);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("shift_start_ignored_adv", prog_advance, 1);
        chk("shift_start_ignored_ready", in_ready, 0);
        chk("shift_start_ignored_state", dbg_state, ST_SHIFT);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_prog_advance", prog_advance, 0);
        chk("abort_prog_enable", prog_enable, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (10) @(negedge clock);
        chk("abort_beats_total", adv_total - base, 35);

        // Async reset off the clock edge in the middle of SHIFT.
        pulse_start();
        send_byte(8'hA5, 1'b0, ok);
        chk("areset_handshake", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_prog_advance", prog_advance, 0);
        chk("areset_prog_enable", prog_enable, 0);
        chk("areset_prog_data", prog_data, 0);
        chk("areset_in_ready", in_ready, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_error", error, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("areset_state_after", dbg_state, ST_IDLE);
        chk("areset_ready_after", in_ready, 0);

        // 4-bit beats: 0xC3 then 0x5A, check byte 0x99.
        s4_start = 1'b1;
        @(negedge clock);
        s4_start = 1'b0;
        chk("w4_start_ready", r4_ready, 1);
        chk("w4_start_enable", r4_enable, 1);
        s4_valid = 1'b1;
        s4_data  = 8'hC3;
        @(negedge clock);
        s4_valid = 1'b0;
        chk("w4_beat0_adv", r4_adv, 1);
        chk("w4_beat0_data", r4_data, 4'hC);
        chk("w4_beat0_ready", r4_ready, 0);
        @(negedge clock);
        chk("w4_beat1_adv", r4_adv, 1);
        chk("w4_beat1_data", r4_data, 4'h3);
        chk("w4_beat1_ready", r4_ready, 0);
        @(negedge clock);
        chk("w4_after_adv", r4_adv, 0);
        chk("w4_after_ready", r4_ready, 1);
        s4_valid = 1'b1;
        s4_data  = 8'h5A;
        @(negedge clock);
        s4_valid = 1'b0;
        chk("w4_b2_beat0", r4_data, 4'h5);
        @(negedge clock);
        chk("w4_b2_beat1", r4_data, 4'hA);
        @(negedge clock);
        chk("w4_check_ready", r4_ready, 1);
        chk("w4_check_state", r4_state, ST_CHECK);
        s4_valid = 1'b1;
        s4_data  = 8'h99;
        @(negedge clock);
        s4_valid = 1'b0;
        chk("w4_done", r4_done, 1);
        chk("w4_error", r4_error, 0);
        chk("w4_enable_off", r4_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
